ifetch_unit: RTL and testbench

- Consumer side of the next-PC interface: owns the program counter, loads `next_ins_addr` from npc on instruction retire, and fetches each instruction from instruction memory over a req/ack handshake.
- Presents `ins` and `ins_addr` back to npc and the decoder, with a valid flag.
- Replaces the free-running PC register, so fetch tolerates multi-cycle memory, core stalls and bus faults.

---
 rtl/ifetch_pkg.sv | 21 ++
 rtl/ifetch_unit.sv | 127 ++++++++++++
 tb/tb_ifetch_unit.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Fault cause encodings reported on err_code.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BUS      = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_MISALIGN = 2'b11;

  // Default program counter after reset.
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_3000;

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time
// from instruction memory and holds it until the core retires it.
//
// Handshakes:
//   imem:  imem_req is raised for a fetch and held, with imem_addr stable,
//          until the cycle in which imem_ack=1 (imem_err qualified by ack)
//          or the wait budget expires. ack is sampled only while waiting,
//          so acks arriving at any other time are ignored.
//   core:  ins/ins_addr are valid while ins_valid=1. The core consumes the
//          instruction with retire=1 && stall=0 in the same cycle, while
//          presenting next_ins_addr; retire under stall is not a transfer.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = DEF_RESET_VECTOR,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_ins_addr,
  input  logic        retire,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_err,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic [31:0] ins_addr,
  output logic        ins_valid,
  output logic        fetch_err,
  output logic [1:0]  err_code,
  output state_t      dbg_state
);

  state_t             state_q;
  logic [31:0]        pc_q;
  logic               imem_req_q;
  logic [31:0]        imem_addr_q;
  logic [31:0]        ins_q;
  logic [31:0]        ins_addr_q;
  logic               ins_valid_q;
  logic               fetch_err_q;
  logic [1:0]         err_code_q;
  logic [CNT_W-1:0]   cnt_q;

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST =
    TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  // Fetch sequencer: all outputs registered, ERR absorbing until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_VECTOR;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_VECTOR;
      ins_q       <= '0;
      ins_addr_q  <= RESET_VECTOR;
      ins_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_REQ: begin
          imem_req_q  <= 1'b1;
          imem_addr_q <= pc_q;
          cnt_q       <= '0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_ack) begin
            imem_req_q <= 1'b0;
            if (imem_err) begin
              // A bus error on the ack cycle overrides the returned data.
              fetch_err_q <= 1'b1;
              err_code_q  <= ERR_BUS;
              state_q     <= S_ERR;
            end else begin
              ins_q       <= imem_rdata;
              ins_addr_q  <= pc_q;
              ins_valid_q <= 1'b1;
              state_q     <= S_HOLD;
            end
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
            err_code_q  <= ERR_TIMEOUT;
            state_q     <= S_ERR;
          end else if (TIMEOUT_EN) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (retire && !stall) begin
            ins_valid_q <= 1'b0;
            if (next_ins_addr[1:0] == 2'b00) begin
              pc_q    <= next_ins_addr;
              state_q <= S_REQ;
            end else begin
              fetch_err_q <= 1'b1;
              err_code_q  <= ERR_MISALIGN;
              state_q     <= S_ERR;
            end
          end
        end
        S_ERR: begin
          imem_req_q  <= 1'b0;
          ins_valid_q <= 1'b0;
        end
        default: state_q <= S_ERR;
      endcase
    end
  end

  assign imem_req  = imem_req_q;
  assign imem_addr = imem_addr_q;
  assign ins       = ins_q;
  assign ins_addr  = ins_addr_q;
  assign ins_valid = ins_valid_q;
  assign fetch_err = fetch_err_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table, directed
// fault/reset sequences and a randomized fetch stream against a PC model.
module tb_ifetch_unit;
  import ifetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: default timeout (16)
  logic [31:0] next_ins_addr = '0;
  logic        retire = 1'b0, stall = 1'b0;
  logic        imem_ack = 1'b0, imem_err = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, ins_valid, fetch_err;
  logic [31:0] imem_addr, ins, ins_addr;
  logic [1:0]  err_code;
  state_t      dbg_state;

  // DUT B: short timeout (4)
  logic        b_ack = 1'b0, b_err = 1'b0;
  logic [31:0] b_rdata = '0;
  logic        b_req, b_ins_valid, b_fetch_err;
  logic [31:0] b_addr, b_ins, b_ins_addr;
  logic [1:0]  b_err_code;
  state_t      b_state;

  ifetch_unit u_dut (
    .clk(clk), .rst(rst), .next_ins_addr(next_ins_addr), .retire(retire),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_err(imem_err), .imem_rdata(imem_rdata),
    .ins(ins), .ins_addr(ins_addr), .ins_valid(ins_valid),
    .fetch_err(fetch_err), .err_code(err_code), .dbg_state(dbg_state)
  );

  ifetch_unit #(.TIMEOUT_CYCLES(4)) u_dut_to (
    .clk(clk), .rst(rst), .next_ins_addr(32'h0), .retire(1'b0),
    .stall(1'b0), .imem_req(b_req), .imem_addr(b_addr),
    .imem_ack(b_ack), .imem_err(b_err), .imem_rdata(b_rdata),
    .ins(b_ins), .ins_addr(b_ins_addr), .ins_valid(b_ins_valid),
    .fetch_err(b_fetch_err), .err_code(b_err_code), .dbg_state(b_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];            // {expected address, expected word}
  logic [31:0] mem [logic [31:0]];  // memory contents by address

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0; imem_err = 1'b0; retire = 1'b0; stall = 1'b0;
    b_ack = 1'b0; b_err = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  // One fetch/retire round trip, starting with the DUT in REQ.
  task automatic run_fetch(input int delay, input int stall_cyc, input logic [31:0] nxt);
    logic [63:0] e;
    logic [31:0] ea, ew;
    int req_cycles;
    bit moved, req_in_stall, drop_in_stall;
    e = exp_q.pop_front();
    ea = e[63:32]; ew = e[31:0];
    tick();
    check("req_rise", imem_req, 1'b1);
    check("req_addr", imem_addr, ea);
    check("no_valid_in_req", ins_valid, 1'b0);
    req_cycles = 1; moved = 1'b0;
    for (int k = 0; k <= delay; k++) begin
      imem_ack   = (k == delay);
      imem_rdata = (k == delay) ? mem_word(imem_addr) : $urandom();
      tick();
      if (imem_req) begin
        req_cycles++;
        if (imem_addr !== ea) moved = 1'b1;
      end
    end
    imem_ack = 1'b0;
    check("req_cycles", req_cycles, delay + 1);
    check("addr_stable", moved, 1'b0);
    check("ins_valid", ins_valid, 1'b1);
    check("ins", ins, ew);
    check("ins_addr", ins_addr, ea);
    check("no_err", fetch_err, 1'b0);
    retire = 1'b1; stall = 1'b1;
    req_in_stall = 1'b0; drop_in_stall = 1'b0;
    for (int s = 0; s < stall_cyc; s++) begin
      next_ins_addr = $urandom();
      tick();
      if (imem_req) req_in_stall = 1'b1;
      if (!ins_valid || ins !== ew) drop_in_stall = 1'b1;
    end
    check("no_req_in_stall", req_in_stall, 1'b0);
    check("hold_in_stall", drop_in_stall, 1'b0);
    stall = 1'b0; next_ins_addr = nxt;
    tick();
    retire = 1'b0;
    check("valid_drop", ins_valid, 1'b0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] pc_exp;
    logic [31:0] word;
    int          delay;
    int          stall_cyc;
    logic [31:0] next_pc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc_m, nx;
    int n;

    vecs[0] = '{32'h0000_3000, 32'h2402_0005, 0, 3, 32'h0000_3004};
    vecs[1] = '{32'h0000_3004, 32'h8C43_0000, 5, 0, 32'h0000_3008};
    vecs[2] = '{32'h0000_3008, 32'hAAAA_5555, 15, 1, 32'h0000_0000};
    vecs[3] = '{32'h0000_0000, 32'h1234_5678, 2, 2, 32'hFFFF_FFFC};
    vecs[4] = '{32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 0, 32'h0000_3000};

    // Reset values
    do_reset();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h3000);
    check("rst_ins", ins, 32'h0);
    check("rst_ins_addr", ins_addr, 32'h3000);
    check("rst_valid", ins_valid, 1'b0);
    check("rst_err", fetch_err, 1'b0);
    check("rst_code", err_code, 2'b00);
    check("rst_state", dbg_state, S_REQ);

    // Table-driven fetches
    foreach (vecs[i]) begin
      mem[vecs[i].pc_exp] = vecs[i].word;
      exp_q.push_back({vecs[i].pc_exp, vecs[i].word});
      run_fetch(vecs[i].delay, vecs[i].stall_cyc, vecs[i].next_pc);
    end

    // Randomized stream against a PC model
    pc_m = 32'h0000_3000;
    for (int i = 0; i < 30; i++) begin
      mem[pc_m] = $urandom();
      exp_q.push_back({pc_m, mem[pc_m]});
      nx = $urandom() & 32'hFFFF_FFFC;
      run_fetch($urandom_range(0, 6), $urandom_range(0, 3), nx);
      pc_m = nx;
    end
    check("q_empty", exp_q.size(), 0);

    // Bus error on ack
    do_reset();
    tick();
    check("be_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_err = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    imem_err = 1'b0;
    check("be_err", fetch_err, 1'b1);
    check("be_code", err_code, ERR_BUS);
    check("be_valid", ins_valid, 1'b0);
    repeat (3) tick();
    imem_ack = 1'b0;
    check("be_absorb_req", imem_req, 1'b0);
    check("be_absorb_valid", ins_valid, 1'b0);
    check("be_absorb_code", err_code, ERR_BUS);
    check("be_state", dbg_state, S_ERR);

    // Misaligned next PC
    do_reset();
    mem[32'h3000] = 32'h2402_0005;
    exp_q.push_back({32'h0000_3000, 32'h2402_0005});
    run_fetch(0, 0, 32'h0000_3006);
    check("mis_err", fetch_err, 1'b1);
    check("mis_code", err_code, ERR_MISALIGN);
    repeat (2) tick();
    check("mis_no_req", imem_req, 1'b0);
    check("mis_valid", ins_valid, 1'b0);

    // Reset during WAIT, stale ack afterwards
    do_reset();
    tick();
    tick();
    check("rw_req_before", imem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("rw_req_drop", imem_req, 1'b0);
    check("rw_addr", imem_addr, 32'h3000);
    check("rw_state", dbg_state, S_REQ);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    exp_q.push_back({32'h0000_3000, 32'h2402_0005});
    run_fetch(1, 0, 32'h0000_3004);

    // Timeout with TIMEOUT_CYCLES=4 (second instance)
    do_reset();
    tick();
    check("to_req", b_req, 1'b1);
    n = 1;
    while (b_req && n < 20) begin
      tick();
      if (b_req) n++;
    end
    check("to_req_cycles", n, 4);
    check("to_err", b_fetch_err, 1'b1);
    check("to_code", b_err_code, ERR_TIMEOUT);
    b_ack = 1'b1; b_rdata = 32'h5555_AAAA;
    repeat (3) tick();
    b_ack = 1'b0;
    check("to_late_ack_valid", b_ins_valid, 1'b0);
    check("to_late_ack_req", b_req, 1'b0);
    check("to_code_sticky", b_err_code, ERR_TIMEOUT);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
